// File: rtl/micro_sequencer.sv
// micro_sequencer: control-store sequencer for a microprogrammed CPU.
// Drives the microcode ROM address (CSAR), latches the returned microword into
// the MIR, computes the next address from COND/JUMP, PSR and IR, stalls on
// memory accesses until acknowledged and raises a one-cycle commit strobe.
//
// Optional build macro MICRO_SEQUENCER_STEP_EN: adds uSEQ_Step_In; leaving IDLE
// then needs Run and Step together, and every completion returns to IDLE so
// exactly one microinstruction runs per Step pulse.
//
// state   | meaning
// IDLE    | parked at an instruction boundary, waiting for Run (and Step)
// FETCH   | ROM word at CSAR is latched into the MIR
// EXEC    | MIR executes; non-memory words commit here
// MEMWAIT | memory access outstanding; waits for ack or the timeout trap

module micro_sequencer #(
   parameter int ADDR_W      = 11,
   parameter int WORD_W      = 41,
   parameter int RESET_ADDR  = 0,
   parameter int TRAP_ADDR   = 2047,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              uSEQ_CLOCK_50,
   input  logic              uSEQ_RESET_InLow,
   input  logic              uSEQ_Run_In,
`ifdef MICRO_SEQUENCER_STEP_EN
   input  logic              uSEQ_Step_In,
`endif
   output logic [ADDR_W-1:0] uSEQ_ROMAddr_Out,
   input  logic [WORD_W-1:0] uSEQ_ROMData_In,
   input  logic [31:0]       uSEQ_IR_In,
   input  logic [3:0]        uSEQ_PSR_In,
   input  logic              uSEQ_MemAck_In,
   output logic [WORD_W-1:0] uSEQ_MIR_Out,
   output logic              uSEQ_Commit_Out,
   output logic              uSEQ_MemRd_Out,
   output logic              uSEQ_MemWr_Out,
   output logic              uSEQ_Timeout_Out,
   output logic [1:0]        uSEQ_State_Out
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_FETCH   = 2'b01,
      ST_EXEC    = 2'b10,
      ST_MEMWAIT = 2'b11
   } state_t;

   // Memory wait timer is a down-counter: loaded with MEM_TIMEOUT-1 on entry,
   // trap when it reaches zero without an ack.
   localparam bit         TO_EN    = (MEM_TIMEOUT != 0);
   localparam logic [7:0] CNT_LOAD = TO_EN ? 8'(MEM_TIMEOUT - 1) : 8'd0;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   csar_q, csar_d;
   logic [WORD_W-1:0]   mir_q;
   logic                load_mir;
   logic [7:0]          cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
   logic [ADDR_W-1:0]   next_addr;
   logic                commit;
   logic                mem_rd;
   logic                mem_wr;
   logic                run_go;

   logic                mir_rd;
   logic                mir_wr;
   logic [2:0]          mir_cond;
   logic [ADDR_W-1:0]   mir_jump;
   logic [ADDR_W-1:0]   csar_inc;
   logic                unused_ir;

   assign mir_rd    = mir_q[19];
   assign mir_wr    = mir_q[18];
   assign mir_cond  = mir_q[13:11];
   assign mir_jump  = ADDR_W'(mir_q[10:0]);
   assign csar_inc  = csar_q + ADDR_W'(1);
   assign unused_ir = ^{uSEQ_IR_In[29:25], uSEQ_IR_In[18:14], uSEQ_IR_In[12:0]};

`ifdef MICRO_SEQUENCER_STEP_EN
   assign run_go = uSEQ_Run_In & uSEQ_Step_In;
`else
   assign run_go = uSEQ_Run_In;
`endif

   // Next control-store address from COND, PSR {n,z,v,c} and IR dispatch.
   always_comb begin
      next_addr = csar_inc;
      case (mir_cond)
         3'b000: next_addr = csar_inc;
         3'b001: next_addr = uSEQ_PSR_In[3] ? mir_jump : csar_inc;
         3'b010: next_addr = uSEQ_PSR_In[2] ? mir_jump : csar_inc;
         3'b011: next_addr = uSEQ_PSR_In[1] ? mir_jump : csar_inc;
         3'b100: next_addr = uSEQ_PSR_In[0] ? mir_jump : csar_inc;
         3'b101: next_addr = uSEQ_IR_In[13] ? mir_jump : csar_inc;
         3'b110: next_addr = mir_jump;
         3'b111: next_addr = ADDR_W'({1'b1, uSEQ_IR_In[31:30], uSEQ_IR_In[24:19], 2'b00});
      endcase
   end

   // FSM next state, CSAR update, wait timer and output strobes.
   always_comb begin
      state_d   = state_q;
      csar_d    = csar_q;
      load_mir  = 1'b0;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      commit    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run_go) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            load_mir = 1'b1;
            state_d  = ST_EXEC;
         end
         ST_EXEC: begin
            mem_rd = mir_rd;
            mem_wr = mir_wr;
            if ((mir_rd | mir_wr) && !uSEQ_MemAck_In) begin
               state_d = ST_MEMWAIT;
               cnt_d   = CNT_LOAD;
            end else begin
               commit = 1'b1;
            end
         end
         ST_MEMWAIT: begin
            mem_rd = mir_rd;
            mem_wr = mir_wr;
            if (uSEQ_MemAck_In) begin
               commit = 1'b1;
            end else if (TO_EN && cnt_q == 8'd0) begin
               csar_d    = ADDR_W'(TRAP_ADDR);
               timeout_d = 1'b1;
`ifdef MICRO_SEQUENCER_STEP_EN
               state_d   = ST_IDLE;
`else
               state_d   = ST_FETCH;
`endif
            end else if (TO_EN) begin
               cnt_d = cnt_q - 8'd1;
            end
         end
      endcase
      // A completed microinstruction always advances CSAR; Run only steers
      // where the FSM goes next.
      if (commit) begin
         csar_d = next_addr;
`ifdef MICRO_SEQUENCER_STEP_EN
         state_d = ST_IDLE;
`else
         state_d = uSEQ_Run_In ? ST_FETCH : ST_IDLE;
`endif
      end
   end

   // State, CSAR, MIR, wait timer and sticky timeout registers.
   always_ff @(posedge uSEQ_CLOCK_50 or negedge uSEQ_RESET_InLow) begin
      if (!uSEQ_RESET_InLow) begin
         state_q   <= ST_IDLE;
         csar_q    <= ADDR_W'(RESET_ADDR);
         mir_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         csar_q    <= csar_d;
         if (load_mir) mir_q <= uSEQ_ROMData_In;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign uSEQ_ROMAddr_Out = csar_q;
   assign uSEQ_MIR_Out     = mir_q;
   assign uSEQ_Commit_Out  = commit;
   assign uSEQ_MemRd_Out   = mem_rd;
   assign uSEQ_MemWr_Out   = mem_wr;
   assign uSEQ_Timeout_Out = timeout_q;
   assign uSEQ_State_Out   = state_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed testbench for micro_sequencer (built with MEM_TIMEOUT=4).
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic [10:0] rom_addr;
   logic [40:0] rom_data;
   logic [31:0] ir = '0;
   logic [3:0]  psr = '0;
   logic        ack = 1'b0;
   logic [40:0] mir;
   logic        commit, memrd, memwr, timeout;
   logic [1:0]  state;

   logic [40:0] rom [0:2047];

   int pass_cnt = 0;
   int total_cnt = 0;

   assign rom_data = rom[rom_addr];

   micro_sequencer #(.MEM_TIMEOUT(4)) dut (
      .uSEQ_CLOCK_50    (clk),
      .uSEQ_RESET_InLow (rst_n),
      .uSEQ_Run_In      (run),
`ifdef MICRO_SEQUENCER_STEP_EN
      .uSEQ_Step_In     (step),
`endif
      .uSEQ_ROMAddr_Out (rom_addr),
      .uSEQ_ROMData_In  (rom_data),
      .uSEQ_IR_In       (ir),
      .uSEQ_PSR_In      (psr),
      .uSEQ_MemAck_In   (ack),
      .uSEQ_MIR_Out     (mir),
      .uSEQ_Commit_Out  (commit),
      .uSEQ_MemRd_Out   (memrd),
      .uSEQ_MemWr_Out   (memwr),
      .uSEQ_Timeout_Out (timeout),
      .uSEQ_State_Out   (state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   function automatic logic [40:0] mkw(input logic [5:0] a, input logic rd, input logic wr,
                                        input logic [2:0] cond, input logic [10:0] jump);
      return {a, 1'b1, 6'h2A, 1'b0, 6'h15, 1'b1, rd, wr, 4'hA, cond, jump};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b0; ack = 1'b0; psr = '0; ir = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Runs one non-memory microinstruction from FETCH and checks the next CSAR.
   task automatic exec_expect(input logic [10:0] exp, input string nm);
      tick();
      total_cnt++;
      if (commit !== 1'b1) $display("FAIL %s commit: got %b want 1", nm, commit);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (state !== 2'b01 || rom_addr !== exp)
         $display("FAIL %s next: got state %b addr %0d want state 01 addr %0d", nm, state, rom_addr, exp);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({state, rom_addr, commit, memrd, memwr, timeout} !== {2'b00, 11'd0, 4'b0000})
         $display("FAIL reset_outputs: got state %b addr %0d c/r/w/t %b%b%b%b want 00 0 0000",
                  state, rom_addr, commit, memrd, memwr, timeout);
      else pass_cnt++;
      total_cnt++;
      if (mir !== 41'd0) $display("FAIL reset_mir: got %h want 0", mir);
      else pass_cnt++;
   endtask

   task automatic test_fetch_exec();
      logic [40:0] w0, w1;
      w0 = mkw(6'd5, 1'b0, 1'b0, 3'b000, 11'd77);
      w1 = mkw(6'd6, 1'b0, 1'b0, 3'b000, 11'd88);
      rom[0] = w0;
      rom[1] = w1;
      do_reset();
      run = 1'b1;
      tick();
      total_cnt++;
      if (state !== 2'b01 || rom_addr !== 11'd0 || commit !== 1'b0)
         $display("FAIL fe_fetch0: got state %b addr %0d commit %b want 01 0 0", state, rom_addr, commit);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (state !== 2'b10 || mir !== w0 || commit !== 1'b1)
         $display("FAIL fe_exec0: got state %b mir %h commit %b want 10 %h 1", state, mir, commit, w0);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (state !== 2'b01 || rom_addr !== 11'd1 || commit !== 1'b0)
         $display("FAIL fe_fetch1: got state %b addr %0d commit %b want 01 1 0", state, rom_addr, commit);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (state !== 2'b10 || mir !== w1 || commit !== 1'b1)
         $display("FAIL fe_exec1: got state %b mir %h commit %b want 10 %h 1", state, mir, commit, w1);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (rom_addr !== 11'd2 || commit !== 1'b0)
         $display("FAIL fe_fetch2: got addr %0d commit %b want 2 0", rom_addr, commit);
      else pass_cnt++;
   endtask

   task automatic test_next_addr();
      rom[0]    = mkw(6'd1, 1'b0, 1'b0, 3'b110, 11'd2);
      rom[2]    = mkw(6'd2, 1'b0, 1'b0, 3'b111, 11'd0);
      rom[1808] = mkw(6'd3, 1'b0, 1'b0, 3'b111, 11'd0);
      rom[1536] = mkw(6'd4, 1'b0, 1'b0, 3'b110, 11'd9);
      rom[9]    = mkw(6'd5, 1'b0, 1'b0, 3'b010, 11'd12);
      rom[12]   = mkw(6'd6, 1'b0, 1'b0, 3'b110, 11'd9);
      rom[10]   = mkw(6'd7, 1'b0, 1'b0, 3'b001, 11'd100);
      rom[100]  = mkw(6'd8, 1'b0, 1'b0, 3'b011, 11'd200);
      rom[101]  = mkw(6'd9, 1'b0, 1'b0, 3'b100, 11'd300);
      rom[300]  = mkw(6'd10, 1'b0, 1'b0, 3'b101, 11'd400);
      rom[400]  = mkw(6'd11, 1'b0, 1'b0, 3'b101, 11'd500);
      rom[401]  = mkw(6'd12, 1'b0, 1'b0, 3'b110, 11'd2047);
      rom[2047] = mkw(6'd13, 1'b0, 1'b0, 3'b000, 11'd5);
      do_reset();
      run = 1'b1;
      tick();
      exec_expect(11'd2, "jump_to_2");
      ir = 32'hC020_0000;
      exec_expect(11'd1808, "decode_c02");
      ir = 32'h8000_0000;
      exec_expect(11'd1536, "decode_800");
      exec_expect(11'd9, "jump_to_9");
      psr = 4'b0100;
      exec_expect(11'd12, "z_taken");
      exec_expect(11'd9, "back_to_9");
      psr = 4'b0000;
      exec_expect(11'd10, "z_not_taken");
      psr = 4'b1000;
      exec_expect(11'd100, "n_taken");
      psr = 4'b1101;
      exec_expect(11'd101, "v_not_taken");
      exec_expect(11'd300, "c_taken");
      ir = 32'h0000_2000;
      exec_expect(11'd400, "ir13_taken");
      ir = 32'hFFFF_DFFF;
      exec_expect(11'd401, "ir13_not_taken");
      exec_expect(11'd2047, "jump_to_2047");
      exec_expect(11'd0, "wrap_2047");
      run = 1'b0;
      tick();
      tick();
      total_cnt++;
      if (state !== 2'b00 || rom_addr !== 11'd2)
         $display("FAIL park_idle: got state %b addr %0d want 00 2", state, rom_addr);
      else pass_cnt++;
   endtask

   task automatic test_mem_read();
      int rd_cyc, wr_cyc, commit_cyc, commit_at;
      rd_cyc = 0; wr_cyc = 0; commit_cyc = 0; commit_at = -1;
      rom[0]  = mkw(6'd20, 1'b1, 1'b0, 3'b000, 11'd0);
      rom[1]  = mkw(6'd21, 1'b1, 1'b0, 3'b110, 11'd40);
      rom[40] = mkw(6'd22, 1'b0, 1'b0, 3'b000, 11'd0);
      do_reset();
      run = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (state !== ((i == 0) ? 2'b10 : 2'b11))
            $display("FAIL rd_state%0d: got %b want %b", i, state, (i == 0) ? 2'b10 : 2'b11);
         else pass_cnt++;
         if (i == 3) begin
            ack = 1'b1;
            #1;
         end
         if (memrd === 1'b1) rd_cyc++;
         if (memwr === 1'b1) wr_cyc++;
         if (commit === 1'b1) begin
            commit_cyc++;
            commit_at = i;
         end
         tick();
      end
      ack = 1'b0;
      total_cnt++;
      if (rd_cyc != 4 || wr_cyc != 0)
         $display("FAIL rd_cycles: got rd %0d wr %0d want rd 4 wr 0", rd_cyc, wr_cyc);
      else pass_cnt++;
      total_cnt++;
      if (commit_cyc != 1 || commit_at != 3)
         $display("FAIL rd_commit: got count %0d at %0d want count 1 at 3", commit_cyc, commit_at);
      else pass_cnt++;
      total_cnt++;
      if (state !== 2'b01 || rom_addr !== 11'd1 || memrd !== 1'b0)
         $display("FAIL rd_after: got state %b addr %0d memrd %b want 01 1 0", state, rom_addr, memrd);
      else pass_cnt++;
      tick();
      ack = 1'b1;
      #1;
      total_cnt++;
      if (commit !== 1'b1 || memrd !== 1'b1 || state !== 2'b10)
         $display("FAIL rd_fast_ack: got commit %b memrd %b state %b want 1 1 10", commit, memrd, state);
      else pass_cnt++;
      tick();
      ack = 1'b0;
      total_cnt++;
      if (state !== 2'b01 || rom_addr !== 11'd40)
         $display("FAIL rd_fast_next: got state %b addr %0d want 01 40", state, rom_addr);
      else pass_cnt++;
   endtask

   task automatic test_run_drop();
      run = 1'b0;
      tick();
      total_cnt++;
      if (commit !== 1'b1 || state !== 2'b10)
         $display("FAIL drop_exec: got commit %b state %b want 1 10", commit, state);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (state !== 2'b00 || rom_addr !== 11'd41)
         $display("FAIL drop_idle: got state %b addr %0d want 00 41", state, rom_addr);
      else pass_cnt++;
      run = 1'b1;
      tick();
      total_cnt++;
      if (state !== 2'b01 || rom_addr !== 11'd41)
         $display("FAIL drop_resume: got state %b addr %0d want 01 41", state, rom_addr);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int wr_cyc, commit_cyc, n;
      wr_cyc = 0; commit_cyc = 0; n = 0;
      rom[0]    = mkw(6'd30, 1'b0, 1'b1, 3'b110, 11'd5);
      rom[2047] = mkw(6'd31, 1'b0, 1'b0, 3'b110, 11'd20);
      rom[20]   = mkw(6'd32, 1'b0, 1'b0, 3'b000, 11'd0);
      rom[21]   = mkw(6'd33, 1'b1, 1'b0, 3'b000, 11'd0);
      do_reset();
      run = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (state !== 2'b10 || timeout !== 1'b0)
         $display("FAIL to_pre: got state %b timeout %b want 10 0", state, timeout);
      else pass_cnt++;
      while (state !== 2'b01 && n < 12) begin
         if (memwr === 1'b1) wr_cyc++;
         if (commit === 1'b1) commit_cyc++;
         n++;
         tick();
      end
      total_cnt++;
      if (wr_cyc != 5 || commit_cyc != 0)
         $display("FAIL to_cycles: got memwr %0d commit %0d want 5 0", wr_cyc, commit_cyc);
      else pass_cnt++;
      total_cnt++;
      if (state !== 2'b01 || rom_addr !== 11'd2047 || timeout !== 1'b1)
         $display("FAIL to_trap: got state %b addr %0d timeout %b want 01 2047 1", state, rom_addr, timeout);
      else pass_cnt++;
      exec_expect(11'd20, "to_after1");
      exec_expect(11'd21, "to_after2");
      total_cnt++;
      if (timeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout);
      else pass_cnt++;
   endtask

   task automatic test_reset_memwait();
      logic [40:0] w;
      tick();
      tick();
      total_cnt++;
      if (state !== 2'b11 || memrd !== 1'b1 || timeout !== 1'b1)
         $display("FAIL rstw_pre: got state %b memrd %b timeout %b want 11 1 1", state, memrd, timeout);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({state, rom_addr, commit, memrd, memwr, timeout} !== {2'b00, 11'd0, 4'b0000})
         $display("FAIL rstw_outputs: got state %b addr %0d c/r/w/t %b%b%b%b want 00 0 0000",
                  state, rom_addr, commit, memrd, memwr, timeout);
      else pass_cnt++;
      total_cnt++;
      if (mir !== 41'd0) $display("FAIL rstw_mir: got %h want 0", mir);
      else pass_cnt++;
      w = mkw(6'd40, 1'b0, 1'b0, 3'b000, 11'd0);
      rom[0] = w;
      run = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      total_cnt++;
      if (state !== 2'b01 || rom_addr !== 11'd0)
         $display("FAIL rstw_fetch: got state %b addr %0d want 01 0", state, rom_addr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (mir !== w || commit !== 1'b1)
         $display("FAIL rstw_exec: got mir %h commit %b want %h 1", mir, commit, w);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (rom_addr !== 11'd1) $display("FAIL rstw_next: got %0d want 1", rom_addr);
      else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) rom[i] = '0;
      test_reset();
      test_fetch_exec();
      test_next_addr();
      test_mem_read();
      test_run_drop();
      test_timeout();
      test_reset_memwait();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Control-store sequencer for the ARC-style microprogrammed CPU.
- Drives the 11-bit address of the microcode ROM and latches the returned 41-bit microword into the MIR.
- Computes the next control-store address from the MIR COND/JUMP fields, the PSR flags and the IR (including the opcode-decode dispatch).
- Stalls the microprogram on memory RD/WR until acknowledged, and issues the single-cycle commit strobe that the datapath uses to write registers and the PSR.

Parameters:
- ADDR_W, 11, control-store address width.
- WORD_W, 41, microword width.
- RESET_ADDR, 0, CSAR value after reset.
- TRAP_ADDR, 2047, CSAR forced on memory timeout.
- MEM_TIMEOUT, 255, maximum MEMWAIT cycles before trap (1..255); 0 disables the timeout.

Ports:
- uSEQ_CLOCK_50  in  1  single system clock, rising edge.
- uSEQ_RESET_InLow  in  1  asynchronous, active-low reset.
- uSEQ_Run_In  in  1  level; 1 = execute microcode, 0 = park in IDLE at the next instruction boundary.
- uSEQ_ROMAddr_Out  out  11  CSAR, drives the microcode ROM address input.
- uSEQ_ROMData_In  in  41  combinational ROM output.
- uSEQ_IR_In  in  32  instruction register.
- uSEQ_PSR_In  in  4  {n,z,v,c}.
- uSEQ_MemAck_In  in  1  memory done, sampled each cycle.
- uSEQ_MIR_Out  out  41  registered microword to the datapath.
- uSEQ_Commit_Out  out  1  one-cycle datapath write strobe.
- uSEQ_MemRd_Out  out  1  memory read request.
- uSEQ_MemWr_Out  out  1  memory write request.
- uSEQ_Timeout_Out  out  1  sticky memory-timeout flag.
- uSEQ_State_Out  out  2  FSM state: IDLE=00, FETCH=01, EXEC=10, MEMWAIT=11.

Behaviour:
- Microword fields (bit 40 down): A[40:35] AMUX[34] B[33:28] BMUX[27] C[26:21] CMUX[20] RD[19] WR[18] ALU[17:14] COND[13:11] JUMP[10:0].
- Reset (async, any state): CSAR=RESET_ADDR, MIR=0, state=IDLE, timeout counter=0. Commit, MemRd, MemWr and Timeout are all 0.
- IDLE: if Run=1, go to FETCH; otherwise hold.
- FETCH: MIR <= ROMData_In (word at the current CSAR); go to EXEC. Commit=0.
- EXEC, RD=WR=0:
  - Commit=1 for this cycle.
  - CSAR <= next.
  - Go to FETCH if Run=1, else IDLE.
- EXEC, RD=1 or WR=1:
  - MemRd=MIR.RD and MemWr=MIR.WR, combinationally from state and MIR.
  - If MemAck=1 this cycle: complete as in the RD=WR=0 case.
  - Otherwise go to MEMWAIT and clear the counter.
- MEMWAIT:
  - MemRd/MemWr held and MIR held; the counter increments each cycle.
  - MemAck=1: Commit=1, CSAR <= next, go to FETCH or IDLE per Run.
  - Counter == MEM_TIMEOUT-1 with no ack (MEM_TIMEOUT>0): CSAR <= TRAP_ADDR, Timeout <= 1 (sticky until reset), Commit=0, go to FETCH.
  - Ack and timeout in the same cycle: ack wins.
- Next-address rule (uses MIR, PSR and IR sampled in the completing cycle). "+1" means CSAR+1 modulo 2^11, so 2047 wraps to 0.
  - 000: +1.
  - 001: JUMP if n, else +1.
  - 010: JUMP if z, else +1.
  - 011: JUMP if v, else +1.
  - 100: JUMP if c, else +1.
  - 101: JUMP if IR[13], else +1.
  - 110: JUMP.
  - 111: decode = {1'b1, IR[31:30], IR[24:19], 2'b00}.
- Timing:
  - Exactly 2 cycles per non-memory microinstruction.
  - Memory microinstructions take 2 + wait cycles.
  - Commit never fires twice for one MIR.
- Run dropping mid-instruction takes effect only at completion. The current microinstruction always finishes.

Optional Feature:
- Macro: MICRO_SEQUENCER_STEP_EN.
- Defined:
  - Adds input port uSEQ_Step_In (1 bit).
  - IDLE -> FETCH requires Run=1 and Step=1 in the same cycle.
  - Every completion (normal, ack or trap) returns to IDLE, so one microinstruction executes per Step pulse.
- Undefined: port absent; behaviour as above.

Test Plan:
- Reset, Run=1, ROM[0] COND=000 and ROM[1] COND=000 -> ROMAddr 0, then 1 after 2 cycles, then 2; Commit high on cycles 2 and 4 only; MIR equals ROM[0] during the first EXEC.
- MIR COND=111 with IR=0xC0200000 (op=11, op3=000100) -> next ROMAddr=1808 (0x710); with IR=0x80000000 -> ROMAddr=1536.
- COND=010, JUMP=12, CSAR=9: PSR z=1 -> ROMAddr=12; z=0 -> ROMAddr=10. COND=000 at CSAR=2047 -> ROMAddr=0.
- RD=1 word, MemAck asserted on the 3rd MEMWAIT cycle -> MemRd high for 4 cycles (EXEC plus 3 MEMWAIT); Commit high only on the ack cycle; then FETCH at CSAR+1.
- MEM_TIMEOUT=4, WR=1, no ack -> MemWr high for 5 cycles, then ROMAddr=2047, Timeout=1, Commit never asserted; Timeout stays 1 through later instructions.
- Assert reset during MEMWAIT -> immediately State=00, ROMAddr=0, MIR=0, Commit, MemRd, MemWr and Timeout all 0; release with Run=1 restarts at address 0.
